// File: rtl/univ_shift_reg.sv
// Universal shift register: load/shift/rotate/clear single steps plus a
// counted burst of shift/rotate steps sequenced by a small IDLE/SHIFT/DONE FSM.
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ser_in_l,
  input  logic             ser_in_r,
  input  logic             start,
  input  logic [LEN_W-1:0] burst_len,
  output logic [WIDTH-1:0] data_out,
  output logic             ser_out_msb,
  output logic             ser_out_lsb,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_CLR  = 3'b110;

  logic [1:0]       state;
  logic [2:0]       burst_op;
  logic [LEN_W-1:0] cnt;
  logic [2:0]       op;
  logic [WIDTH-1:0] step_val;
  logic             burst_mode;

  assign burst_mode = (mode == M_SHL) || (mode == M_SHR) ||
                      (mode == M_ROL) || (mode == M_ROR);

  // During a burst the latched op drives the datapath; the live mode is ignored.
  always_comb begin
    op       = (state == SHIFT) ? burst_op : mode;
    step_val = data_out;
    case (op)
      M_HOLD:  step_val = data_out;
      M_LOAD:  step_val = data_in;
      M_SHL:   step_val = {data_out[WIDTH-2:0], ser_in_l};
      M_SHR:   step_val = {ser_in_r, data_out[WIDTH-1:1]};
      M_ROL:   step_val = {data_out[WIDTH-2:0], data_out[WIDTH-1]};
      M_ROR:   step_val = {data_out[0], data_out[WIDTH-1:1]};
      M_CLR:   step_val = '0;
      default: step_val = data_out;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      data_out <= '0;
      cnt      <= '0;
      burst_op <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && burst_mode) begin
            // Burst acceptance never touches data_out, even with en high.
            burst_op <= mode;
            cnt      <= burst_len;
            state    <= (burst_len != '0) ? SHIFT : DONE;
          end else if (en) begin
            data_out <= step_val;
          end
        end
        SHIFT: begin
          if (en) begin
            data_out <= step_val;
            cnt      <= cnt - 1'b1;
            if (cnt == LEN_W'(1)) state <= DONE;
          end
        end
        DONE: begin
          if (en) data_out <= step_val;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy        = (state == SHIFT);
  assign done        = (state == DONE);
  assign ser_out_msb = data_out[WIDTH-1];
  assign ser_out_lsb = data_out[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8): single ops, enable gating,
// bursts, stalls, burst edge cases and reset mid-burst.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [2:0] mode;
  logic [7:0] data_in;
  logic       ser_in_l, ser_in_r;
  logic       start;
  logic [3:0] burst_len;
  logic [7:0] data_out;
  logic       ser_out_msb, ser_out_lsb, busy, done;

  int tests = 0;
  int fails = 0;

  univ_shift_reg #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .data_in(data_in),
    .ser_in_l(ser_in_l), .ser_in_r(ser_in_r), .start(start),
    .burst_len(burst_len), .data_out(data_out), .ser_out_msb(ser_out_msb),
    .ser_out_lsb(ser_out_lsb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    en = 1'b1; mode = 3'b001; data_in = v; start = 1'b0;
    step();
    mode = 3'b000;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b0; mode = 3'b000; data_in = 8'h00;
    ser_in_l = 1'b0; ser_in_r = 1'b0; start = 1'b0; burst_len = 4'd0;
    #12;
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_data got %h exp 00", data_out); end
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL reset_flags got busy=%b done=%b exp 0 0", busy, done); end
    reset = 1'b0;
    // First edge after deassertion performs the op.
    en = 1'b1; mode = 3'b001; data_in = 8'h77;
    step();
    tests++; if (data_out !== 8'h77) begin fails++; $display("FAIL reset_first_op got %h exp 77", data_out); end
    // Asynchronous assertion clears without a clock edge.
    #1 reset = 1'b1; #1;
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL reset_async got %h exp 00", data_out); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    load(8'hA5);
    tests++; if (data_out !== 8'hA5) begin fails++; $display("FAIL load got %h exp a5", data_out); end
    tests++; if (ser_out_msb !== 1'b1 || ser_out_lsb !== 1'b1) begin fails++; $display("FAIL ser_out got %b%b exp 11", ser_out_msb, ser_out_lsb); end
    mode = 3'b010; ser_in_l = 1'b1; step();
    tests++; if (data_out !== 8'h4B) begin fails++; $display("FAIL shl got %h exp 4b", data_out); end
    load(8'hA5);
    mode = 3'b011; ser_in_r = 1'b0; step();
    tests++; if (data_out !== 8'h52) begin fails++; $display("FAIL shr got %h exp 52", data_out); end
    tests++; if (ser_out_msb !== 1'b0 || ser_out_lsb !== 1'b0) begin fails++; $display("FAIL ser_out2 got %b%b exp 00", ser_out_msb, ser_out_lsb); end
    mode = 3'b111; step();
    tests++; if (data_out !== 8'h52) begin fails++; $display("FAIL reserved_hold got %h exp 52", data_out); end
    mode = 3'b110; step();
    tests++; if (data_out !== 8'h00) begin fails++; $display("FAIL clear got %h exp 00", data_out); end
    mode = 3'b000;
  endtask

  task automatic test_rotate_enable();
    load(8'h81);
    mode = 3'b100; step();
    tests++; if (data_out !== 8'h03) begin fails++; $display("FAIL rol got %h exp 03", data_out); end
    load(8'h81);
    mode = 3'b101; step();
    tests++; if (data_out !== 8'hC0) begin fails++; $display("FAIL ror got %h exp c0", data_out); end
    en = 1'b0; mode = 3'b001; data_in = 8'hFF; step();
    tests++; if (data_out !== 8'hC0) begin fails++; $display("FAIL en0_load got %h exp c0", data_out); end
    mode = 3'b110; step();
    tests++; if (data_out !== 8'hC0) begin fails++; $display("FAIL en0_clear got %h exp c0", data_out); end
    mode = 3'b010; ser_in_l = 1'b1; step();
    tests++; if (data_out !== 8'hC0) begin fails++; $display("FAIL en0_shl got %h exp c0", data_out); end
    en = 1'b1; mode = 3'b000;
  endtask

  task automatic test_burst();
    logic [7:0] exp_d [3];
    exp_d[0] = 8'h4B; exp_d[1] = 8'hA5; exp_d[2] = 8'hD2;
    load(8'h96);
    start = 1'b1; mode = 3'b101; burst_len = 4'd3; step();
    start = 1'b0; mode = 3'b000;
    tests++; if (busy !== 1'b1 || done !== 1'b0 || data_out !== 8'h96) begin fails++; $display("FAIL burst_accept got busy=%b done=%b d=%h exp 1 0 96", busy, done, data_out); end
    for (int i = 0; i < 3; i++) begin
      // A start pulse plus load mode mid-burst must be ignored.
      if (i == 1) begin start = 1'b1; mode = 3'b001; data_in = 8'hFF; burst_len = 4'd5; end
      step();
      start = 1'b0; mode = 3'b000;
      tests++; if (data_out !== exp_d[i]) begin fails++; $display("FAIL burst_step%0d got %h exp %h", i, data_out, exp_d[i]); end
      tests++; if (busy !== (i < 2) || done !== (i == 2)) begin fails++; $display("FAIL burst_flags%0d got busy=%b done=%b", i, busy, done); end
    end
    step();
    tests++; if (busy !== 1'b0 || done !== 1'b0 || data_out !== 8'hD2) begin fails++; $display("FAIL burst_after got busy=%b done=%b d=%h exp 0 0 d2", busy, done, data_out); end
  endtask

  task automatic test_stall();
    logic       en_seq [5];
    logic [7:0] exp_d  [5];
    int busy_cnt, done_cnt;
    en_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_d  = '{8'h4B, 8'h4B, 8'h4B, 8'hA5, 8'hD2};
    load(8'h96);
    start = 1'b1; mode = 3'b101; burst_len = 4'd3; step();
    start = 1'b0; mode = 3'b000;
    busy_cnt = busy ? 1 : 0; done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      en = en_seq[i]; step();
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      tests++; if (data_out !== exp_d[i]) begin fails++; $display("FAIL stall_step%0d got %h exp %h", i, data_out, exp_d[i]); end
    end
    en = 1'b1; step();
    if (done) done_cnt++;
    tests++; if (busy_cnt !== 5) begin fails++; $display("FAIL stall_busy_cycles got %0d exp 5", busy_cnt); end
    tests++; if (done_cnt !== 1) begin fails++; $display("FAIL stall_done_pulses got %0d exp 1", done_cnt); end
    tests++; if (data_out !== 8'hD2) begin fails++; $display("FAIL stall_final got %h exp d2", data_out); end
  endtask

  task automatic test_edge_cases();
    load(8'h3C);
    start = 1'b1; mode = 3'b010; burst_len = 4'd0; ser_in_l = 1'b1; step();
    start = 1'b0; mode = 3'b000;
    tests++; if (done !== 1'b1 || busy !== 1'b0 || data_out !== 8'h3C) begin fails++; $display("FAIL len0 got busy=%b done=%b d=%h exp 0 1 3c", busy, done, data_out); end
    step();
    tests++; if (done !== 1'b0 || busy !== 1'b0 || data_out !== 8'h3C) begin fails++; $display("FAIL len0_after got busy=%b done=%b d=%h exp 0 0 3c", busy, done, data_out); end
    start = 1'b1; mode = 3'b001; data_in = 8'h5A; burst_len = 4'd3; step();
    start = 1'b0; mode = 3'b000;
    tests++; if (data_out !== 8'h5A || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL start_load got busy=%b done=%b d=%h exp 0 0 5a", busy, done, data_out); end
    step();
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL start_load_after got busy=%b done=%b exp 0 0", busy, done); end
    // SHL burst samples the live serial input on every step.
    load(8'h00);
    start = 1'b1; mode = 3'b010; burst_len = 4'd2; step();
    start = 1'b0; mode = 3'b000;
    ser_in_l = 1'b1; step();
    ser_in_l = 1'b0; step();
    tests++; if (data_out !== 8'h02 || done !== 1'b1) begin fails++; $display("FAIL shl_burst_serial got d=%h done=%b exp 02 1", data_out, done); end
    step();
  endtask

  task automatic test_reset_mid_burst();
    int done_cnt;
    load(8'h96);
    start = 1'b1; mode = 3'b101; burst_len = 4'd3; step();
    start = 1'b0; mode = 3'b000;
    step(); step();
    tests++; if (data_out !== 8'hA5 || busy !== 1'b1) begin fails++; $display("FAIL mid_pre got d=%h busy=%b exp a5 1", data_out, busy); end
    reset = 1'b1; #2;
    tests++; if (data_out !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL mid_reset got d=%h busy=%b done=%b exp 00 0 0", data_out, busy, done); end
    reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (done || busy) done_cnt++;
    end
    tests++; if (done_cnt !== 0 || data_out !== 8'h00) begin fails++; $display("FAIL mid_after got flag_cycles=%0d d=%h exp 0 00", done_cnt, data_out); end
  endtask

  initial begin
    fork
      begin
        test_reset();
        test_single();
        test_rotate_enable();
        test_burst();
        test_stall();
        test_edge_cases();
        test_reset_mid_burst();
      end
      begin
        #100000;
        fails++;
        $display("FAIL timeout got still running exp finished");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
